mult_sequencer: RTL and testbench

//  Sequencer for the iterative HI/LO multiply unit driven from the execute stage (startMultE, signedMultE, mfRegE).

---
 rtl/mult_sequencer_pkg.sv | 19 +
 rtl/mult_sequencer_if.sv | 29 ++
 rtl/mult_shift_add_step.sv | 23 ++
 rtl/mult_sequencer.sv | 115 +++++++++++
 tb/tb_mult_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sequencer_pkg.sv
// Shared codes for the HI/LO multiply sequencer: FSM states and the
// MFHI/MFLO and MTHI/MTLO selector encodings used by the execute stage.
package mult_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam logic [1:0] MF_NONE = 2'b00;
  localparam logic [1:0] MF_LO   = 2'b01;
  localparam logic [1:0] MF_HI   = 2'b10;

  localparam logic [1:0] MT_NONE = 2'b00;
  localparam logic [1:0] MT_LO   = 2'b01;
  localparam logic [1:0] MT_HI   = 2'b10;

endpackage

// File: rtl/mult_sequencer_if.sv
// Execute-stage view of the multiply unit: request/operand inputs and the
// stall, status and HI/LO read-back outputs.
interface mult_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic             signed_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [1:0]       mf_reg_i;
  logic [1:0]       mt_reg_i;
  logic [WIDTH-1:0] mt_data_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] mf_data_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, signed_i, a_i, b_i, mf_reg_i, mt_reg_i, mt_data_i,
    input  stall_o, busy_o, done_o, mf_data_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, signed_i, a_i, b_i, mf_reg_i, mt_reg_i, mt_data_i,
    output stall_o, busy_o, done_o, mf_data_o, hi_o, lo_o
  );
endinterface

// File: rtl/mult_shift_add_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into
// the upper half, then shift the {acc, mplier} pair right by one.
module mult_shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mplier_next
);

  // The carry out of the add is kept so the shift brings it into acc's MSB.
  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc};
    if (mplier[0]) sum = sum + {1'b0, mcand};
    acc_next    = sum[WIDTH:1];
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_sequencer.sv
// Iterative HI/LO multiply sequencer: magnitude shift-add over WIDTH cycles,
// sign fix-up, HI/LO ownership and the pipeline stall request.
module mult_sequencer
  import mult_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  mult_sequencer_if.slave bus
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mplier, mcand;
  logic [WIDTH-1:0] acc_next, mplier_next;
  logic             neg;
  logic [WIDTH-1:0] hi, lo;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] product, product_fixed;

  // Magnitudes of a two's-complement minimum still fit in WIDTH unsigned bits.
  assign a_mag = (bus.signed_i && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign b_mag = (bus.signed_i && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;

  assign product       = {acc, mplier};
  assign product_fixed = neg ? -product : product;

  mult_shift_add_step #(.WIDTH(WIDTH)) u_step (
    .acc        (acc),
    .mplier     (mplier),
    .mcand      (mcand),
    .acc_next   (acc_next),
    .mplier_next(mplier_next)
  );

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.start_i) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      acc    <= '0;
      mplier <= '0;
      mcand  <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            mplier <= a_mag;
            mcand  <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= bus.signed_i & (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
          end else if (bus.mt_reg_i == MT_LO) begin
            lo <= bus.mt_data_i;
          end else if (bus.mt_reg_i == MT_HI) begin
            hi <= bus.mt_data_i;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          cnt    <= cnt + CW'(1);
        end
        FIX: begin
          hi <= product_fixed[2*WIDTH-1:WIDTH];
          lo <= product_fixed[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o  = (state != IDLE);
  assign bus.done_o  = (state == FIX);
  // An accepted start never stalls: in IDLE busy_o is low.
  assign bus.stall_o = bus.busy_o &
                       (bus.start_i | (bus.mf_reg_i != MF_NONE) | (bus.mt_reg_i != MT_NONE));
  assign bus.hi_o    = hi;
  assign bus.lo_o    = lo;

  always_comb begin
    bus.mf_data_o = '0;
    unique case (bus.mf_reg_i)
      MF_LO:   bus.mf_data_o = lo;
      MF_HI:   bus.mf_data_o = hi;
      default: bus.mf_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: hand-computed products, latency,
// stall behaviour, MTHI/MTLO, and asynchronous reset during a multiply.
module tb_mult_sequencer;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  mult_sequencer_if #(.WIDTH(W)) bus ();

  mult_sequencer #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the accept edge (inclusive) until done_o is seen.
  task automatic wait_done(output int edges);
    edges = 1;
    while (bus.done_o !== 1'b1 && edges < 200) begin
      tick();
      edges++;
    end
  endtask

  task automatic run_mult(input string tag, input logic sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
    int edges;
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    bus.a_i      = a;
    bus.b_i      = b;
    #1;
    check({tag, "_accept_stall"}, 64'(bus.stall_o), 64'd0);
    tick();
    bus.start_i = 1'b0;
    wait_done(edges);
    check({tag, "_latency"}, 64'(edges), 64'd33);
    tick();
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
    check({tag, "_idle"}, {62'd0, bus.busy_o, bus.done_o}, 64'd0);
  endtask

  initial begin
    int  edges;
    bit  held;
    bit  saw_done;

    bus.start_i   = 1'b0;
    bus.signed_i  = 1'b0;
    bus.a_i       = '0;
    bus.b_i       = '0;
    bus.mf_reg_i  = 2'b00;
    bus.mt_reg_i  = 2'b00;
    bus.mt_data_i = '0;

    // Reset and idle state
    #2 reset = 1'b0;
    tick();
    tick();
    check("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    check("rst_flags", {61'd0, bus.stall_o, bus.busy_o, bus.done_o}, 64'd0);
    reset = 1'b1;
    tick();
    bus.mf_reg_i = 2'b10;
    #1;
    check("idle_mfhi_data", 64'(bus.mf_data_o), 64'd0);
    check("idle_mfhi_stall", 64'(bus.stall_o), 64'd0);
    bus.mf_reg_i = 2'b00;

    // Products: -21, 2^64-2^33+1, 1, zero
    run_mult("s7xm3", 1'b1, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_mult("u_ffff_sq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mult("s_m1_sq", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_mult("u_zero", 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);

    // Signed min squared with an MFHI arriving mid-multiply
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b1;
    bus.a_i      = 32'h8000_0000;
    bus.b_i      = 32'h8000_0000;
    tick();
    bus.start_i = 1'b0;
    edges = 1;
    tick(); edges++;
    tick(); edges++;
    bus.mf_reg_i = 2'b10;
    #1;
    held = 1'b1;
    while (bus.done_o !== 1'b1 && edges < 200) begin
      if (bus.stall_o !== 1'b1) held = 1'b0;
      tick();
      edges++;
    end
    check("smin_mf_stall_held", 64'(held), 64'd1);
    check("smin_latency", 64'(edges), 64'd33);
    check("smin_stall_in_fix", 64'(bus.stall_o), 64'd1);
    tick();
    check("smin_stall_after", 64'(bus.stall_o), 64'd0);
    check("smin_mfhi", 64'(bus.mf_data_o), 64'h4000_0000);
    check("smin_lo", 64'(bus.lo_o), 64'd0);
    bus.mf_reg_i = 2'b00;

    // Back-to-back MULT: second start held by stall until IDLE
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'd3;
    bus.b_i      = 32'd5;
    tick();
    bus.a_i = 32'h0001_0000;
    bus.b_i = 32'h0001_0000;
    #1;
    held = 1'b1;
    edges = 0;
    while (bus.busy_o === 1'b1 && edges < 200) begin
      if (bus.stall_o !== 1'b1) held = 1'b0;
      tick();
      edges++;
    end
    check("b2b_stall_held", 64'(held), 64'd1);
    check("b2b_first_busy_edges", 64'(edges), 64'd33);
    check("b2b_first_result", {bus.hi_o, bus.lo_o}, 64'd15);
    check("b2b_idle_stall", 64'(bus.stall_o), 64'd0);
    tick();
    bus.start_i = 1'b0;
    check("b2b_second_busy", 64'(bus.busy_o), 64'd1);
    wait_done(edges);
    check("b2b_second_latency", 64'(edges), 64'd33);
    tick();
    check("b2b_second_result", {bus.hi_o, bus.lo_o}, 64'h0000_0001_0000_0000);

    // MTLO while busy stalls and is not written; in IDLE it writes
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'd2;
    bus.b_i      = 32'd3;
    tick();
    bus.start_i   = 1'b0;
    bus.mt_reg_i  = 2'b01;
    bus.mt_data_i = 32'h0000_1234;
    #1;
    held = 1'b1;
    edges = 0;
    while (bus.busy_o === 1'b1 && edges < 200) begin
      if (bus.stall_o !== 1'b1) held = 1'b0;
      tick();
      edges++;
    end
    check("mt_busy_stall_held", 64'(held), 64'd1);
    check("mt_busy_not_written", {bus.hi_o, bus.lo_o}, 64'd6);
    tick();
    check("mtlo_idle_write", {bus.hi_o, bus.lo_o}, 64'h0000_1234);
    bus.mt_reg_i  = 2'b10;
    bus.mt_data_i = 32'h0000_ABCD;
    tick();
    check("mthi_idle_write", {bus.hi_o, bus.lo_o}, 64'h0000_ABCD_0000_1234);

    // Start with MTHI and MFLO in the same IDLE cycle: start wins, MF sees old LO
    bus.start_i   = 1'b1;
    bus.signed_i  = 1'b0;
    bus.a_i       = 32'd1;
    bus.b_i       = 32'd1;
    bus.mt_reg_i  = 2'b10;
    bus.mt_data_i = 32'hDEAD_BEEF;
    bus.mf_reg_i  = 2'b01;
    #1;
    check("start_mf_pre_lo", 64'(bus.mf_data_o), 64'h0000_1234);
    tick();
    bus.start_i  = 1'b0;
    bus.mt_reg_i = 2'b00;
    bus.mf_reg_i = 2'b00;
    check("start_wins_hi", 64'(bus.hi_o), 64'h0000_ABCD);
    wait_done(edges);
    tick();
    check("start_wins_result", {bus.hi_o, bus.lo_o}, 64'd1);

    // Asynchronous reset at RUN cycle 10
    bus.start_i  = 1'b1;
    bus.signed_i = 1'b0;
    bus.a_i      = 32'hFFFF_FFFF;
    bus.b_i      = 32'hFFFF_FFFF;
    tick();
    bus.start_i  = 1'b0;
    bus.mf_reg_i = 2'b01;
    repeat (10) tick();
    check("abort_pre_stall", 64'(bus.stall_o), 64'd1);
    reset = 1'b0;
    #1;
    check("abort_flags", {61'd0, bus.stall_o, bus.busy_o, bus.done_o}, 64'd0);
    check("abort_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    tick();
    reset = 1'b1;
    bus.mf_reg_i = 2'b00;
    saw_done = 1'b0;
    repeat (40) begin
      if (bus.done_o === 1'b1) saw_done = 1'b1;
      tick();
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    run_mult("post_abort", 1'b1, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
